vga_scanout: RTL and testbench
==============================

# vga_scanout

Parametrised VGA scan-out engine, successor to the fixed 640x480 `VGA_DRIVER`. It generates programmable horizontal and vertical timing with selectable sync polarity, and pulls RGB565 pixels from the framebuffer read FIFO through a valid/ready handshake. It expands them to 8-bit-per-channel VGA outputs and detects FIFO underflow. It sits between the SDRAM read port and the VGA DAC pins, clocked by the PLL pixel clock.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, active level of `VGA_HS`
- `VS_POL`, 0, active level of `VGA_VS`
- `CNT_W`, 11, counter width; must satisfy 2^CNT_W ≥ max(H_TOTAL, V_TOTAL)
- `UF_COLOR`, 16'hF81F, RGB565 value substituted on underflow
- `clk_pix` in 1: pixel clock, the only clock
- `rst_n` in 1: reset, synchronous, active-low
- `mode` in 2: 0 = stream, 1 = colour bars, 2 = solid `UF_COLOR`, 3 = treated as 0
- `pix_data` in 16: RGB565 pixel from the framebuffer FIFO
- `pix_valid` in 1: `pix_data` is valid
- `pix_ready` out 1: engine consumes a pixel this cycle
- `uf_clr` in 1: clears `uf_cnt`
- `VGA_HS`, `VGA_VS` out 1 each: sync outputs
- `VGA_BLANK_N` out 1: high during the visible region
- `VGA_SYNC_N` out 1: constant 0 (no sync-on-green)
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: colour outputs
- `H_Cont`, `V_Cont` out CNT_W each: current counter position
- `frame_start` out 1: one-cycle pulse at position (0,0)
- `uf_cnt` out 16: saturating underflow count

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
- `H_Cont` runs 0..H_TOTAL-1, then wraps to 0. At that wrap, `V_Cont` increments, running 0..V_TOTAL-1 and wrapping.
- Line segment order: active (0..H_ACTIVE-1), front porch, sync, back porch. Vertical follows the same order.
- The engine is in the active region when `H_Cont` < H_ACTIVE and `V_Cont` < V_ACTIVE.
- Sync is asserted (at HS_POL/VS_POL level) for H_Cont in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Vertical sync uses the same rule on `V_Cont`.
- `mode` is sampled into `mode_q` only in the cycle where `frame_start`=1, so a mode change never tears a frame.
- Stream mode:
  - `pix_ready` = active region (combinational from the counter registers).
  - If active and `pix_valid` = 1: the pixel is consumed.
  - If active and `pix_valid` = 0: output `UF_COLOR`, and `uf_cnt` increments, saturating at 16'hFFFF.
  - Outside the active region, `pix_ready` = 0 and `pix_valid` is ignored.
- Colour bars mode: `pix_ready` = 0. Bar index = H_Cont·8/H_ACTIVE. Bars in order: white, yellow, cyan, green, magenta, red, blue, black.
- Solid mode: `pix_ready` = 0; every active pixel is `UF_COLOR`.
- RGB565 expansion: R8 = {r5, r5[4:2]}, G8 = {g6, g6[5:4]}, B8 = {b5, b5[4:2]}.
- Outside the active region the RGB outputs are 0.
- `uf_clr` clears `uf_cnt` to 0. If an underflow occurs in the same cycle, the clear wins.

## Timing
- Stage 0: counter registers. `H_Cont`, `V_Cont`, `frame_start` and `pix_ready` are valid in the same cycle.
- Stage 1: registered VGA outputs. `VGA_HS`, `VGA_VS`, `VGA_BLANK_N` and RGB reflect the stage-0 position one cycle later.
- A pixel accepted at cycle n appears on `VGA_R/G/B` at cycle n+1.
- While `rst_n` = 0, at the next edge:
  - counters go to 0, `mode_q` to 0, `uf_cnt` to 0;
  - `VGA_HS` goes to ~HS_POL and `VGA_VS` to ~VS_POL;
  - `VGA_BLANK_N`, RGB and `VGA_SYNC_N` go to 0;
  - `pix_ready` and `frame_start` are forced to 0.
- First cycle after release: counters are at (0,0) and `frame_start` = 1.
- Reset asserted mid-frame aborts the frame. No partial-frame state survives.
- `frame_start` period is exactly H_TOTAL·V_TOTAL cycles (420000 at defaults).

## Structure
- Package `vga_pkg`:
  - `vga_mode_e` enum;
  - timing localparam sets for 640x480@60, 800x600@60 and 1280x720@60;
  - colour-bar RGB565 constants;
  - `rgb565_to_888` function.
- Sub-module `vga_timing_counter`: H/V counters, region decode and sync decode, parametrised by the timing parameters.
- Top level holds the handshake, pattern mux, underflow counter and output registers.

## Test plan
- Defaults, `mode`=0, `pix_valid` held 1 → `frame_start` period 420000 cycles; `VGA_HS` low for 96 cycles per 800-cycle line, starting at H_Cont=656; `VGA_VS` low 2 lines starting at V_Cont=490; exactly 307200 `pix_ready` cycles per frame.
- Stream `pix_data`=16'hF800 at H_Cont=0 → next cycle RGB = FF/00/00 and `VGA_BLANK_N`=1.
- Drop `pix_valid` for 5 active cycles → RGB = FF/00/FF for those pixels; `uf_cnt`=5. Then `uf_clr` pulse → 0.
- Switch `mode` to 1 mid-frame → output unchanged until the next `frame_start`. Then the pixel at H_Cont=80 is yellow (FF/FF/00), H_Cont=560 is black, and `pix_ready` stays 0.
- Override to H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, V_ACTIVE=600, V_FP=1, V_SYNC=4, V_BP=23, HS_POL=VS_POL=1 → line 1056 cycles, frame 628 lines, syncs high-active.
- Assert `rst_n`=0 at V_Cont=200 → next edge: all outputs at reset values. Release → `frame_start`=1 on the first cycle after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types, timing presets, colour-bar palette and RGB565 expansion
// for the VGA scan-out engine.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_STREAM = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_SOLID  = 2'd2
    } vga_mode_e;

    localparam int VGA640_H_ACTIVE  = 640;
    localparam int VGA640_H_FP      = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BP      = 48;
    localparam int VGA640_V_ACTIVE  = 480;
    localparam int VGA640_V_FP      = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BP      = 33;

    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    localparam int HD720_H_ACTIVE   = 1280;
    localparam int HD720_H_FP       = 110;
    localparam int HD720_H_SYNC     = 40;
    localparam int HD720_H_BP       = 220;
    localparam int HD720_V_ACTIVE   = 720;
    localparam int HD720_V_FP       = 5;
    localparam int HD720_V_SYNC     = 5;
    localparam int HD720_V_BP       = 20;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

    // MSB replication so full-scale 5/6-bit codes map to 8'hFF.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical position counters with active-region and sync decode.
module vga_timing_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CNT_W    = 11
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hs_on,
    output logic             vs_on,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SY_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SY_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SY_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SY_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_d, h_q, v_d, v_q;
    logic             run_d, run_q;

    // run_q holds the counters at (0,0) for the first cycle after reset release
    // so that cycle is the frame start.
    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        run_d = 1'b1;
        if (run_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            h_q   <= '0;
            v_q   <= '0;
            run_q <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            run_q <= run_d;
        end
    end

    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign active      = run_q && (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_on       = run_q && (h_q >= H_SY_BEG) && (h_q < H_SY_END);
    assign vs_on       = run_q && (v_q >= V_SY_BEG) && (v_q < V_SY_END);
    assign frame_start = run_q && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out engine: pixel handshake, pattern mux, underflow counting and
// registered DAC outputs on top of the timing counter.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int          CNT_W    = 11,
    parameter logic [15:0] UF_COLOR = 16'hF81F
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [15:0]      pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             uf_clr,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK_N,
    output logic             VGA_SYNC_N,
    output logic [7:0]       VGA_R,
    output logic [7:0]       VGA_G,
    output logic [7:0]       VGA_B,
    output logic [CNT_W-1:0] H_Cont,
    output logic [CNT_W-1:0] V_Cont,
    output logic             frame_start,
    output logic [15:0]      uf_cnt
);

    localparam logic [CNT_W+2:0] H_ACT_X = (CNT_W + 3)'(H_ACTIVE);

    logic             active, hs_on, vs_on;
    vga_mode_e        mode_in, mode_cur, mode_d, mode_q;
    logic [CNT_W+2:0] h_x8;
    logic [2:0]       bar_idx;
    logic [15:0]      pix565;
    logic             underflow;
    logic [15:0]      uf_d, uf_q;
    logic             hs_d, hs_q, vs_d, vs_q, blank_d, blank_q;
    logic [23:0]      rgb_d, rgb_q;

    vga_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CNT_W(CNT_W)
    ) u_timing (
        .clk_pix    (clk_pix),
        .rst_n      (rst_n),
        .h_cnt      (H_Cont),
        .v_cnt      (V_Cont),
        .active     (active),
        .hs_on      (hs_on),
        .vs_on      (vs_on),
        .frame_start(frame_start)
    );

    // Stage 0: the frame-start cycle already uses the newly sampled mode,
    // so every pixel of a frame sees the same mode.
    always_comb begin
        mode_in   = (mode == 2'd3) ? MODE_STREAM : vga_mode_e'(mode);
        mode_cur  = frame_start ? mode_in : mode_q;
        mode_d    = mode_cur;
        pix_ready = active && (mode_cur == MODE_STREAM);
        underflow = pix_ready && !pix_valid;
        h_x8      = {H_Cont, 3'b000};
        bar_idx   = 3'(h_x8 / H_ACT_X);

        pix565 = '0;
        if (active) begin
            case (mode_cur)
                MODE_STREAM: pix565 = pix_valid ? pix_data : UF_COLOR;
                MODE_BARS:   pix565 = bar_color(bar_idx);
                default:     pix565 = UF_COLOR;
            endcase
        end
        rgb_d   = rgb565_to_888(pix565);
        blank_d = active;
        hs_d    = hs_on ? HS_POL : ~HS_POL;
        vs_d    = vs_on ? VS_POL : ~VS_POL;

        uf_d = uf_q;
        if (uf_clr)
            uf_d = '0;
        else if (underflow && (uf_q != 16'hFFFF))
            uf_d = uf_q + 16'd1;
    end

    // Stage 1: registered DAC-side outputs.
    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            mode_q  <= MODE_STREAM;
            uf_q    <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            uf_q    <= uf_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
        end
    end

    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign uf_cnt      = uf_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: small-timing instance against a position/frame model,
// plus an 800x600 positive-sync instance for line-level timing.
module tb_vga_scanout;

    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam int UFC = 16'hF81F;

    logic clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        uf_clr = 1'b0;

    logic        a_ready, a_hs, a_vs, a_blank, a_sync_n, a_fs;
    logic [7:0]  a_r, a_g, a_b;
    logic [10:0] a_h, a_v;
    logic [15:0] a_uf;
    logic        b_ready, b_hs, b_vs, b_blank, b_sync_n, b_fs;
    logic [7:0]  b_r, b_g, b_b;
    logic [10:0] b_h, b_v;
    logic [15:0] b_uf;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .mode(mode), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(a_ready), .uf_clr(uf_clr),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_blank), .VGA_SYNC_N(a_sync_n),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .H_Cont(a_h), .V_Cont(a_v),
        .frame_start(a_fs), .uf_cnt(a_uf)
    );

    vga_scanout #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_svga (
        .clk_pix(clk_pix), .rst_n(rst_n), .mode(mode), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(b_ready), .uf_clr(uf_clr),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_blank), .VGA_SYNC_N(b_sync_n),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .H_Cont(b_h), .V_Cont(b_v),
        .frame_start(b_fs), .uf_cnt(b_uf)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position from elapsed cycles since release.
    int          t = 0;
    int          uf_exp = 0;
    int          m_mode = 0;
    int          mode_next = 0;
    int          valid_knob = 1;   // 0 random, 1 always, 2 never
    int          clr_knob = 1;     // 0 random, 1 never, 2 always
    int          force_data = -1;
    logic        e_hs = 1'b1, e_vs = 1'b1, e_blank = 1'b0;
    logic [23:0] e_rgb = '0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] exp565(input int p);
        int r5 = (p >> 11) & 31;
        int g6 = (p >> 5) & 63;
        int b5 = p & 31;
        return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
    endfunction

    task automatic step();
        int h, v;
        bit act, fs;
        @(negedge clk_pix);
        h = t % HT;
        v = (t / HT) % VT;
        check("h_cont", a_h, h);
        check("v_cont", a_v, v);
        check("vga_hs", a_hs, e_hs);
        check("vga_vs", a_vs, e_vs);
        check("blank_n", a_blank, e_blank);
        check("rgb", {a_r, a_g, a_b}, e_rgb);
        check("sync_n", a_sync_n, 0);
        check("uf_cnt", a_uf, uf_exp);

        mode      = 2'(mode_next);
        pix_valid = (valid_knob == 1) ? 1'b1 : (valid_knob == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        pix_data  = (force_data >= 0) ? 16'(force_data) : 16'($urandom);
        uf_clr    = (clr_knob == 2) ? 1'b1 : (clr_knob == 1) ? 1'b0 : ($urandom_range(0, 15) == 0);
        #1;
        fs = ((t % FT) == 0);
        if (fs) m_mode = (mode_next == 3) ? 0 : mode_next;
        act = (h < HA) && (v < VA);
        check("frame_start", a_fs, fs);
        check("pix_ready", a_ready, act && (m_mode == 0));

        e_rgb = '0;
        if (act) begin
            if (m_mode == 0)      e_rgb = pix_valid ? exp565(pix_data) : exp565(UFC);
            else if (m_mode == 1) e_rgb = bars[h * 8 / HA];
            else                  e_rgb = exp565(UFC);
        end
        e_blank = act;
        e_hs = (h >= HA + HFP && h < HA + HFP + HSW) ? 1'b0 : 1'b1;
        e_vs = (v >= VA + VFP && v < VA + VFP + VSW) ? 1'b0 : 1'b1;
        if (uf_clr) uf_exp = 0;
        else if (act && m_mode == 0 && !pix_valid && uf_exp < 65535) uf_exp++;
        t++;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_pix);
        rst_n = 1'b0;
        pix_valid = 1'b0;
        uf_clr = 1'b0;
        repeat (cycles) @(negedge clk_pix);
        check("rst_h", a_h, 0);
        check("rst_v", a_v, 0);
        check("rst_fs", a_fs, 0);
        check("rst_ready", a_ready, 0);
        check("rst_hs", a_hs, 1);
        check("rst_vs", a_vs, 1);
        check("rst_blank", a_blank, 0);
        check("rst_rgb", {a_r, a_g, a_b}, 0);
        check("rst_sync_n", a_sync_n, 0);
        check("rst_uf", a_uf, 0);
        check("rst_svga_sync", {b_hs, b_vs, b_sync_n, b_blank, b_fs, b_ready}, 0);
        check("rst_svga_out", {b_r, b_g, b_b, b_uf}, 0);
        check("rst_svga_pos", {b_h, b_v}, 0);
        rst_n = 1'b1;
        t = 0; uf_exp = 0; m_mode = 0;
        e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_rgb = '0;
    endtask

    task automatic measure_main();
        int k, n, rdy, hsn, vsn, hs_first;
        k = 0;
        @(negedge clk_pix); #2;
        while (!a_fs && k < 2 * FT) begin @(negedge clk_pix); #2; k++; end
        check("fs_found", a_fs, 1);
        n = 0; rdy = 0; hsn = 0; vsn = 0; hs_first = -1;
        do begin
            rdy += int'(a_ready);
            if (!a_hs) begin hsn++; if (hs_first < 0) hs_first = int'(a_h); end
            if (!a_vs) vsn++;
            @(negedge clk_pix); #2;
            n++;
        end while (!a_fs && n < 2 * FT);
        check("fs_period", n, FT);
        check("ready_per_frame", rdy, HA * VA);
        check("hs_low_per_frame", hsn, HSW * VT);
        check("vs_low_per_frame", vsn, VSW * HT);
        // Registered HS trails the counter by one pixel.
        check("hs_first_hcont", hs_first, HA + HFP + 1);
    endtask

    task automatic measure_svga();
        int k, n, hsn, vsn, hs_first;
        logic [10:0] v0;
        v0 = b_v; k = 0;
        while (b_v == v0 && k < 2200) begin @(negedge clk_pix); #2; k++; end
        check("svga_line_seen", b_v != v0, 1);
        v0 = b_v; n = 0; hsn = 0; vsn = 0; hs_first = -1;
        while (b_v == v0 && n < 2200) begin
            if (b_hs) begin hsn++; if (hs_first < 0) hs_first = int'(b_h); end
            if (b_vs) vsn++;
            @(negedge clk_pix); #2;
            n++;
        end
        check("svga_line_len", n, 1056);
        check("svga_hs_high", hsn, 128);
        check("svga_hs_first", hs_first, 800 + 40 + 1);
        check("svga_vs_idle", vsn, 0);
    endtask

    initial begin
        do_reset(3);

        force_data = 16'hF800;
        step();
        force_data = -1;
        valid_knob = 2;
        @(posedge clk_pix); #1;
        check("f800_rgb", {a_r, a_g, a_b}, 24'hFF0000);
        check("f800_blank", a_blank, 1);
        repeat (5) step();
        valid_knob = 1;
        @(posedge clk_pix); #1;
        check("uf_rgb", {a_r, a_g, a_b}, 24'hFF00FF);
        check("uf_five", a_uf, 5);
        clr_knob = 2;
        step();
        clr_knob = 1;
        @(posedge clk_pix); #1;
        check("uf_cleared", a_uf, 0);

        clr_knob = 0;
        fork
            repeat (3000) step();
            measure_main();
            measure_svga();
        join

        valid_knob = 0;
        while ((t % FT) != FT / 2) step();
        mode_next = 1;
        step();
        while ((t % FT) != 0) step();
        while (((t - 1) % FT) != 2) step();
        @(posedge clk_pix); #1;
        check("bar_yellow", {a_r, a_g, a_b}, 24'hFFFF00);
        while (((t - 1) % FT) != 14) step();
        @(posedge clk_pix); #1;
        check("bar_black", {a_r, a_g, a_b}, 24'h000000);
        check("bar_ready", a_ready, 0);

        mode_next = 2;
        repeat (FT + 20) step();
        mode_next = 3;
        repeat (2 * FT) step();
        mode_next = 0;
        repeat ($urandom_range(FT, 2 * FT)) step();

        while ((t % FT) != 3 * HT + 5) step();
        do_reset(2);
        @(posedge clk_pix); #1;
        check("fs_after_rst", a_fs, 1);
        check("pos_after_rst", {a_h, a_v}, 0);
        repeat (2 * FT) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
